// File: rtl/branch_predict_track.sv
// Branch metadata tracker: carries local-predictor state from Fetch through
// Decode to Execute, resolves each branch once in E, and produces the
// predictor training strobe, mispredict redirect and performance counters.
module branch_predict_track #(
    parameter int PHT_INDEX_BITS = 7,
    parameter int BHT_INDEX_BITS = 3,
    parameter int CNT_BITS       = 32
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      validF,
    input  logic [31:0]               pcF,
    input  logic                      predict_takeF,
    input  logic [BHT_INDEX_BITS-1:0] pc_hashingF,
    input  logic [PHT_INDEX_BITS-1:0] PHT_indexF,
    input  logic                      stallD,
    input  logic                      flushD,
    input  logic                      stallE,
    input  logic                      flushE,
    input  logic                      is_branchD,
    input  logic [31:0]               branch_targetD,
    input  logic                      branch_takenE,
    output logic                      branchE,
    output logic [BHT_INDEX_BITS-1:0] BHT_indexE,
    output logic [PHT_INDEX_BITS-1:0] PHT_indexE,
    output logic                      actually_takenE,
    output logic                      predict_resultE,
    output logic                      mispredictE,
    output logic [31:0]               redirect_pcE,
    output logic                      pred_redirectD,
    output logic [CNT_BITS-1:0]       branch_cnt,
    output logic [CNT_BITS-1:0]       mispredict_cnt
);

    logic                      vldD_q;
    logic [31:0]               pcD_q;
    logic                      predD_q;
    logic [BHT_INDEX_BITS-1:0] bhtD_q;
    logic [PHT_INDEX_BITS-1:0] phtD_q;

    logic                      vldE_q;
    logic                      brE_q;
    logic [31:0]               pcE_q;
    logic                      predE_q;
    logic [BHT_INDEX_BITS-1:0] bhtE_q;
    logic [PHT_INDEX_BITS-1:0] phtE_q;
    logic [31:0]               targetE_q;

    logic                      done_q, done_d;
    logic [CNT_BITS-1:0]       branchCnt_q, branchCnt_d;
    logic [CNT_BITS-1:0]       mispredictCnt_q, mispredictCnt_d;

    logic                      fire;

    // Decode stage register: flush clears, stall holds, otherwise capture fetch
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vldD_q  <= 1'b0;
            pcD_q   <= '0;
            predD_q <= 1'b0;
            bhtD_q  <= '0;
            phtD_q  <= '0;
        end else if (flushD) begin
            vldD_q  <= 1'b0;
        end else if (!stallD) begin
            vldD_q  <= validF;
            pcD_q   <= pcF;
            predD_q <= predict_takeF;
            bhtD_q  <= pc_hashingF;
            phtD_q  <= PHT_indexF;
        end
    end

    // Execute stage register: a D entry being flushed this cycle enters E invalid
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            vldE_q    <= 1'b0;
            brE_q     <= 1'b0;
            pcE_q     <= '0;
            predE_q   <= 1'b0;
            bhtE_q    <= '0;
            phtE_q    <= '0;
            targetE_q <= '0;
        end else if (flushE) begin
            vldE_q    <= 1'b0;
        end else if (!stallE) begin
            vldE_q    <= vldD_q & ~flushD;
            brE_q     <= vldD_q & is_branchD;
            pcE_q     <= pcD_q;
            predE_q   <= predD_q;
            bhtE_q    <= bhtD_q;
            phtE_q    <= phtD_q;
            targetE_q <= branch_targetD;
        end
    end

    // Resolution outputs; everything is forced to zero unless a branch resolves now
    always_comb begin
        fire            = vldE_q & brE_q & ~done_q;
        branchE         = fire;
        mispredictE     = fire & (predE_q != branch_takenE);
        actually_takenE = fire & branch_takenE;
        predict_resultE = fire & branch_takenE;
        BHT_indexE      = fire ? bhtE_q : '0;
        PHT_indexE      = fire ? phtE_q : '0;
        redirect_pcE    = '0;
        if (mispredictE) begin
            redirect_pcE = branch_takenE ? targetE_q : (pcE_q + 32'd8);
        end
        pred_redirectD  = vldD_q & is_branchD & predD_q & ~stallD & ~flushD;
    end

    // Done flag keeps a stalled E branch from training twice; counters saturate
    always_comb begin
        done_d = done_q;
        if (flushE || !stallE) begin
            done_d = 1'b0;
        end else if (fire) begin
            done_d = 1'b1;
        end
        branchCnt_d     = branchCnt_q;
        mispredictCnt_d = mispredictCnt_q;
        if (branchE && (branchCnt_q != '1)) begin
            branchCnt_d = branchCnt_q + CNT_BITS'(1);
        end
        if (mispredictE && (mispredictCnt_q != '1)) begin
            mispredictCnt_d = mispredictCnt_q + CNT_BITS'(1);
        end
    end

    // Done flag and performance counter registers
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            done_q          <= 1'b0;
            branchCnt_q     <= '0;
            mispredictCnt_q <= '0;
        end else begin
            done_q          <= done_d;
            branchCnt_q     <= branchCnt_d;
            mispredictCnt_q <= mispredictCnt_d;
        end
    end

    assign branch_cnt     = branchCnt_q;
    assign mispredict_cnt = mispredictCnt_q;

endmodule

// File: tb/tb_branch_predict_track.sv
// Directed bench for branch_predict_track: a table of single-branch vectors
// followed by hand-written stall, flush and reset sequences.
module tb_branch_predict_track;

    logic        clk;
    logic        rst;
    logic        validF;
    logic [31:0] pcF;
    logic        predict_takeF;
    logic [2:0]  pc_hashingF;
    logic [6:0]  PHT_indexF;
    logic        stallD, flushD, stallE, flushE;
    logic        is_branchD;
    logic [31:0] branch_targetD;
    logic        branch_takenE;
    logic        branchE;
    logic [2:0]  BHT_indexE;
    logic [6:0]  PHT_indexE;
    logic        actually_takenE;
    logic        predict_resultE;
    logic        mispredictE;
    logic [31:0] redirect_pcE;
    logic        pred_redirectD;
    logic [31:0] branch_cnt;
    logic [31:0] mispredict_cnt;

    int checks = 0;
    int errors = 0;
    int expBrCnt = 0;
    int expMisCnt = 0;

    typedef struct {
        logic [31:0] pc;
        logic        pred;
        logic [2:0]  bht;
        logic [6:0]  pht;
        logic [31:0] target;
        logic        taken;
        logic        isBr;
        logic        expBranch;
        logic        expMis;
        logic [31:0] expRedirect;
    } vec_t;

    vec_t vecs[6];

    branch_predict_track dut (
        .clk(clk), .rst(rst), .validF(validF), .pcF(pcF),
        .predict_takeF(predict_takeF), .pc_hashingF(pc_hashingF),
        .PHT_indexF(PHT_indexF), .stallD(stallD), .flushD(flushD),
        .stallE(stallE), .flushE(flushE), .is_branchD(is_branchD),
        .branch_targetD(branch_targetD), .branch_takenE(branch_takenE),
        .branchE(branchE), .BHT_indexE(BHT_indexE), .PHT_indexE(PHT_indexE),
        .actually_takenE(actually_takenE), .predict_resultE(predict_resultE),
        .mispredictE(mispredictE), .redirect_pcE(redirect_pcE),
        .pred_redirectD(pred_redirectD), .branch_cnt(branch_cnt),
        .mispredict_cnt(mispredict_cnt)
    );

    // Free-running 10 ns clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, actual, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one instruction in F for the coming edge
    task automatic applyStimulus(input logic [31:0] pc, input logic pred, input logic [2:0] bht, input logic [6:0] pht);
        validF        = 1'b1;
        pcF           = pc;
        predict_takeF = pred;
        pc_hashingF   = bht;
        PHT_indexF    = pht;
    endtask

    task automatic clearF();
        validF        = 1'b0;
        pcF           = '0;
        predict_takeF = 1'b0;
        pc_hashingF   = '0;
        PHT_indexF    = '0;
    endtask

    task automatic checkIdle(input string tag);
        checkOutput({tag, "_branchE"}, 32'(branchE), 32'd0);
        checkOutput({tag, "_mispredictE"}, 32'(mispredictE), 32'd0);
        checkOutput({tag, "_bht"}, 32'(BHT_indexE), 32'd0);
        checkOutput({tag, "_pht"}, 32'(PHT_indexE), 32'd0);
        checkOutput({tag, "_redirect"}, redirect_pcE, 32'd0);
    endtask

    int strobes;

    initial begin
        vecs[0] = '{32'h0000_0100, 1'b1, 3'd3, 7'h15, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[1] = '{32'h0000_0300, 1'b0, 3'd5, 7'h2A, 32'h0000_0200, 1'b1, 1'b1, 1'b1, 1'b1, 32'h0000_0200};
        vecs[2] = '{32'h0000_0100, 1'b1, 3'd7, 7'h7F, 32'h0000_0400, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0108};
        vecs[3] = '{32'hFFFF_FFFC, 1'b1, 3'd1, 7'h01, 32'h0000_0800, 1'b0, 1'b1, 1'b1, 1'b1, 32'h0000_0004};
        vecs[4] = '{32'h0000_0500, 1'b0, 3'd2, 7'h40, 32'h0000_0900, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0};
        vecs[5] = '{32'h0000_0600, 1'b1, 3'd4, 7'h33, 32'h0000_0A00, 1'b1, 1'b0, 1'b0, 1'b0, 32'h0};

        rst = 1'b0;
        clearF();
        stallD = 0; flushD = 0; stallE = 0; flushE = 0;
        is_branchD = 0; branch_targetD = '0; branch_takenE = 0;

        tick();
        checkIdle("reset");
        checkOutput("reset_branch_cnt", branch_cnt, 32'd0);
        checkOutput("reset_pred_redirectD", 32'(pred_redirectD), 32'd0);
        rst = 1'b1;
        tick();

        // Table-driven single-branch vectors, no stalls
        for (int i = 0; i < 6; i++) begin
            applyStimulus(vecs[i].pc, vecs[i].pred, vecs[i].bht, vecs[i].pht);
            tick();
            clearF();
            is_branchD     = vecs[i].isBr;
            branch_targetD = vecs[i].target;
            #1;
            checkOutput($sformatf("v%0d_pred_redirectD", i), 32'(pred_redirectD), 32'(vecs[i].isBr & vecs[i].pred));
            tick();
            is_branchD    = 1'b0;
            branch_takenE = vecs[i].taken;
            #1;
            checkOutput($sformatf("v%0d_branchE", i), 32'(branchE), 32'(vecs[i].expBranch));
            checkOutput($sformatf("v%0d_mispredictE", i), 32'(mispredictE), 32'(vecs[i].expMis));
            checkOutput($sformatf("v%0d_bht", i), 32'(BHT_indexE), vecs[i].expBranch ? 32'(vecs[i].bht) : 32'd0);
            checkOutput($sformatf("v%0d_pht", i), 32'(PHT_indexE), vecs[i].expBranch ? 32'(vecs[i].pht) : 32'd0);
            checkOutput($sformatf("v%0d_actually", i), 32'(actually_takenE), 32'(vecs[i].expBranch & vecs[i].taken));
            checkOutput($sformatf("v%0d_predres", i), 32'(predict_resultE), 32'(vecs[i].expBranch & vecs[i].taken));
            if (vecs[i].expMis)
                checkOutput($sformatf("v%0d_redirect", i), redirect_pcE, vecs[i].expRedirect);
            if (vecs[i].expBranch) expBrCnt++;
            if (vecs[i].expMis) expMisCnt++;
            tick();
            branch_takenE = 1'b0;
            #1;
            checkOutput($sformatf("v%0d_oneshot", i), 32'(branchE), 32'd0);
            checkOutput($sformatf("v%0d_branch_cnt", i), branch_cnt, 32'(expBrCnt));
            checkOutput($sformatf("v%0d_mispredict_cnt", i), mispredict_cnt, 32'(expMisCnt));
        end

        // Predicted-taken branch in D: stallD and flushD suppress the early redirect
        applyStimulus(32'h0000_0700, 1'b1, 3'd6, 7'h11);
        tick();
        clearF();
        is_branchD = 1'b1;
        branch_targetD = 32'h0000_0B00;
        stallD = 1'b1;
        #1;
        checkOutput("stallD_pred_redirectD", 32'(pred_redirectD), 32'd0);
        stallD = 1'b0;
        flushD = 1'b1;
        #1;
        checkOutput("flushD_pred_redirectD", 32'(pred_redirectD), 32'd0);
        flushD = 1'b0;
        #1;
        checkOutput("free_pred_redirectD", 32'(pred_redirectD), 32'd1);

        // Branch held in E for 4 stalled cycles trains exactly once
        tick();
        is_branchD = 1'b0;
        stallE = 1'b1;
        branch_takenE = 1'b1;
        strobes = 0;
        for (int c = 0; c < 4; c++) begin
            #1;
            if (branchE) strobes++;
            tick();
        end
        stallE = 1'b0;
        branch_takenE = 1'b0;
        expBrCnt++;
        #1;
        checkOutput("stallE_strobes", 32'(strobes), 32'd1);
        checkOutput("stallE_branch_cnt", branch_cnt, 32'(expBrCnt));
        checkOutput("stallE_mispredict_cnt", mispredict_cnt, 32'(expMisCnt));
        tick();
        checkOutput("stallE_after_release", 32'(branchE), 32'd0);

        // flushE as the branch would enter E: no strobe, counters unchanged
        applyStimulus(32'h0000_0800, 1'b0, 3'd2, 7'h22);
        tick();
        clearF();
        is_branchD = 1'b1;
        branch_targetD = 32'h0000_0C00;
        flushE = 1'b1;
        tick();
        flushE = 1'b0;
        is_branchD = 1'b0;
        branch_takenE = 1'b1;
        #1;
        checkIdle("flushE");
        tick();
        checkOutput("flushE_branch_cnt", branch_cnt, 32'(expBrCnt));
        checkOutput("flushE_mispredict_cnt", mispredict_cnt, 32'(expMisCnt));
        branch_takenE = 1'b0;

        // Asynchronous reset while a mispredicted branch sits in E
        applyStimulus(32'h0000_0900, 1'b0, 3'd5, 7'h55);
        tick();
        clearF();
        is_branchD = 1'b1;
        branch_targetD = 32'h0000_0D00;
        tick();
        is_branchD = 1'b0;
        branch_takenE = 1'b1;
        #1;
        checkOutput("prereset_mispredictE", 32'(mispredictE), 32'd1);
        #1;
        rst = 1'b0;
        #1;
        checkIdle("asyncrst");
        checkOutput("asyncrst_branch_cnt", branch_cnt, 32'd0);
        checkOutput("asyncrst_mispredict_cnt", mispredict_cnt, 32'd0);
        rst = 1'b1;
        tick();
        checkOutput("postrst_branchE_0", 32'(branchE), 32'd0);
        tick();
        checkOutput("postrst_branchE_1", 32'(branchE), 32'd0);
        checkOutput("postrst_branch_cnt", branch_cnt, 32'd0);
        branch_takenE = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
